// File: rtl/layernorm_pkg.sv
// Shared widths and FSM state encoding for the layernorm statistics stages.
package layernorm_pkg;
    localparam int X_W     = 9;
    localparam int EX_W    = 8;
    localparam int ALPHA_W = 2;
    localparam int INV_N_W = 8;
    localparam int SQ_W    = 17;
    localparam int EX2_W   = 30;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CALC1 = 3'd3,
        ST_CALC2 = 3'd4,
        ST_DONE  = 3'd5
    } var_state_e;
endpackage

// File: rtl/comp_square.sv
// Compress-and-square datapath: arithmetic right shift by alpha, then square.
module comp_square
    import layernorm_pkg::*;
(
    input  logic signed [X_W-1:0]     i_x,
    input  logic        [ALPHA_W-1:0] i_alpha,
    output logic        [SQ_W-1:0]    o_sq
);

    logic signed [X_W-1:0]   xc_s;
    logic signed [2*X_W-1:0] sq_full_s;

    // Square is never negative and |-256|^2 = 65536 still fits in 17 bits.
    always_comb begin
        xc_s      = i_x >>> i_alpha;
        sq_full_s = (2*X_W)'(xc_s) * (2*X_W)'(xc_s);
        o_sq      = SQ_W'(sq_full_s);
    end

endmodule

// File: rtl/var_unit.sv
// Variance stage: accumulates squared compressed samples, then E[x^2] - E[x]^2.
// Optional build macro VAR_UNIT_SAT_EN makes the accumulator saturate instead of wrap.
module var_unit
    import layernorm_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_valid,
    input  logic signed [X_W-1:0]     i_x,
    input  logic        [ALPHA_W-1:0] i_alpha,
    input  logic        [INV_N_W-1:0] i_inv_n,
    input  logic signed [EX_W-1:0]    i_Ex,
    input  logic                      i_Ex_done,
    output logic                      o_busy,
    output logic                      o_var_done,
    output logic        [OUT_W-1:0]   o_var,
    output logic                      o_ovf
);

    localparam logic [EX2_W-1:0] OUT_MAX = {{(EX2_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    var_state_e                state_r;
    logic [ACC_W-1:0]          acc_r;
    logic                      ex_flag_r;
    logic signed [EX_W-1:0]    ex_r;
    logic [ALPHA_W-1:0]        alpha_r;
    logic [INV_N_W-1:0]        inv_n_r;
    logic [EX2_W-1:0]          ex2_r;
    logic [2*EX_W-1:0]         ex_sq_r;
    logic [EX2_W-1:0]          diff_r;

    logic [ALPHA_W-1:0]        alpha_sel_s;
    logic [SQ_W-1:0]           sq_s;
    logic [ACC_W-1:0]          acc_base_s;
    logic [ACC_W-1:0]          acc_next_s;
    logic                      acc_ovf_s;
    logic [ACC_W+INV_N_W-1:0]  prod_s;
    logic [EX2_W-1:0]          ex2_s;
    logic signed [2*EX_W-1:0]  ex_sq_s;
    logic [EX2_W-1:0]          diff_s;
    logic                      var_sat_s;

    comp_square u_comp_square (
        .i_x     (i_x),
        .i_alpha (alpha_sel_s),
        .o_sq    (sq_s)
    );

    // The first sample of a vector uses the live alpha and a zero accumulator base.
    always_comb begin
        if (state_r == ST_IDLE) begin
            alpha_sel_s = i_alpha;
            acc_base_s  = {ACC_W{1'b0}};
        end else begin
            alpha_sel_s = alpha_r;
            acc_base_s  = acc_r;
        end
    end

`ifdef VAR_UNIT_SAT_EN
    logic [ACC_W:0] sum_s;

    // Saturating accumulate: carry out clamps to all ones and flags overflow.
    always_comb begin
        sum_s = {1'b0, acc_base_s} + (ACC_W+1)'(sq_s);
        if (sum_s[ACC_W]) begin
            acc_next_s = {ACC_W{1'b1}};
            acc_ovf_s  = 1'b1;
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
            acc_ovf_s  = 1'b0;
        end
    end
`else
    // Wrapping accumulate: overflow is silently modulo 2^ACC_W.
    always_comb begin
        acc_next_s = acc_base_s + ACC_W'(sq_s);
        acc_ovf_s  = 1'b0;
    end
`endif

    // Post-accumulation arithmetic, all floored.
    always_comb begin
        prod_s    = (ACC_W+INV_N_W)'(acc_r) * (ACC_W+INV_N_W)'(inv_n_r);
        ex2_s     = EX2_W'((prod_s >> INV_N_W) << {alpha_r, 1'b0});
        ex_sq_s   = (2*EX_W)'(ex_r) * (2*EX_W)'(ex_r);
        if (ex2_r < EX2_W'(ex_sq_r)) begin
            diff_s = {EX2_W{1'b0}};
        end else begin
            diff_s = ex2_r - EX2_W'(ex_sq_r);
        end
        var_sat_s = (diff_r > OUT_MAX);
    end

    // Sequencer with registered status and result outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r    <= ST_IDLE;
            acc_r      <= {ACC_W{1'b0}};
            ex_flag_r  <= 1'b0;
            ex_r       <= {EX_W{1'b0}};
            alpha_r    <= {ALPHA_W{1'b0}};
            inv_n_r    <= {INV_N_W{1'b0}};
            ex2_r      <= {EX2_W{1'b0}};
            ex_sq_r    <= {(2*EX_W){1'b0}};
            diff_r     <= {EX2_W{1'b0}};
            o_busy     <= 1'b0;
            o_var_done <= 1'b0;
            o_var      <= {OUT_W{1'b0}};
            o_ovf      <= 1'b0;
        end else begin
            o_var_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        state_r   <= ST_ACC;
                        o_busy    <= 1'b1;
                        acc_r     <= acc_next_s;
                        ex_flag_r <= 1'b0;
                        o_ovf     <= acc_ovf_s;
                        alpha_r   <= i_alpha;
                        inv_n_r   <= i_inv_n;
                    end
                end
                ST_ACC: begin
                    if (i_valid) begin
                        acc_r <= acc_next_s;
                        if (acc_ovf_s) begin
                            o_ovf <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                    if (i_Ex_done) begin
                        ex_r      <= i_Ex;
                        ex_flag_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (ex_flag_r || i_Ex_done) begin
                        state_r <= ST_CALC1;
                    end
                    if (i_Ex_done) begin
                        ex_r      <= i_Ex;
                        ex_flag_r <= 1'b1;
                    end
                end
                ST_CALC1: begin
                    ex2_r   <= ex2_s;
                    ex_sq_r <= $unsigned(ex_sq_s);
                    state_r <= ST_CALC2;
                end
                ST_CALC2: begin
                    diff_r  <= diff_s;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    o_var_done <= 1'b1;
                    o_busy     <= 1'b0;
                    state_r    <= ST_IDLE;
                    if (var_sat_s) begin
                        o_var <= {OUT_W{1'b1}};
                        o_ovf <= 1'b1;
                    end else begin
                        o_var <= diff_r[OUT_W-1:0];
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_var_unit.sv
// Directed self-checking bench for var_unit; expectations are hand-computed.
module tb_var_unit;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic              i_valid;
    logic signed [8:0] i_x;
    logic [1:0]        i_alpha;
    logic [7:0]        i_inv_n;
    logic signed [7:0] i_Ex;
    logic              i_Ex_done;
    logic              o_busy;
    logic              o_var_done;
    logic [15:0]       o_var;
    logic              o_ovf;

    int errors = 0;
    int checks = 0;

    var_unit #(.ACC_W(24), .OUT_W(16)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_valid    (i_valid),
        .i_x        (i_x),
        .i_alpha    (i_alpha),
        .i_inv_n    (i_inv_n),
        .i_Ex       (i_Ex),
        .i_Ex_done  (i_Ex_done),
        .o_busy     (o_busy),
        .o_var_done (o_var_done),
        .o_var      (o_var),
        .o_ovf      (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Drives one vector from a negedge; alpha/inv_n are scrambled after the first sample.
    task automatic send_vec(input int n, input bit ramp, input int cval, input logic [1:0] a,
                            input logic [7:0] inv, input logic signed [7:0] ex, input bit ex_last);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_x     = ramp ? 9'(i + 1) : 9'(cval);
            i_alpha = (i == 0) ? a : ~a;
            i_inv_n = (i == 0) ? inv : ~inv;
            if (ex_last && i == n - 1) begin
                i_Ex_done = 1'b1;
                i_Ex      = ex;
            end
            @(negedge i_clk);
        end
        i_valid   = 1'b0;
        i_Ex_done = 1'b0;
        i_x       = 9'sd0;
    endtask

    // Counts posedges until o_var_done is seen at a negedge, bounded at 20.
    task automatic wait_done(output int n);
        n = 0;
        while (!o_var_done && n < 20) begin
            @(posedge i_clk);
            @(negedge i_clk);
            n++;
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_valid = 1'b0; i_x = 9'sd0; i_alpha = 2'd0; i_inv_n = 8'd0;
        i_Ex = 8'sd0; i_Ex_done = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_var_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_var_done); end
        checks++; if (o_var !== 16'd0) begin errors++; $display("FAIL reset_var got=%0d exp=0", o_var); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
        i_rstn = 1'b1;
        @(negedge i_clk);
    endtask

    // acc=4*1024=4096, ex2=(4096*255>>8)<<6=261120 -> saturates
    task automatic test_out_sat();
        int n;
        send_vec(4, 1'b0, -256, 2'd3, 8'd255, 8'sd0, 1'b1);
        wait_done(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL sat_latency got=%0d exp=5", n); end
        checks++; if (o_var !== 16'hFFFF) begin errors++; $display("FAIL sat_var got=%0d exp=65535", o_var); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b exp=1", o_ovf); end
        @(negedge i_clk);
    endtask

    // sum 1..8 squared = 204, (204*32)>>8 = 25, 25-16 = 9
    task automatic test_ramp();
        int n;
        send_vec(8, 1'b1, 0, 2'd0, 8'd32, 8'sd4, 1'b1);
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ramp_ovf_cleared got=%b exp=0", o_ovf); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ramp_busy got=%b exp=1", o_busy); end
        wait_done(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL ramp_latency got=%0d exp=5", n); end
        checks++; if (o_var !== 16'd9) begin errors++; $display("FAIL ramp_var got=%0d exp=9", o_var); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_idle got=%b exp=0", o_busy); end
        @(negedge i_clk);
        checks++; if (o_var_done !== 1'b0) begin errors++; $display("FAIL ramp_done_width got=%b exp=0", o_var_done); end
        checks++; if (o_var !== 16'd9) begin errors++; $display("FAIL ramp_var_hold got=%0d exp=9", o_var); end
    endtask

    // shifted squares sum 8, (8*32>>8)<<4 = 16, 16-16 = 0
    task automatic test_alpha2();
        int n;
        send_vec(8, 1'b1, 0, 2'd2, 8'd32, 8'sd4, 1'b1);
        wait_done(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL alpha2_latency got=%0d exp=5", n); end
        checks++; if (o_var !== 16'd0) begin errors++; $display("FAIL alpha2_var got=%0d exp=0", o_var); end
        @(negedge i_clk);
    endtask

    // Ex_done in IDLE ignored; late Ex_done 5 cycles after valid falls; valid in WAIT ignored.
    task automatic test_ex_late();
        int n;
        bit bad;
        i_Ex_done = 1'b1; i_Ex = 8'sd100;
        @(negedge i_clk);
        i_Ex_done = 1'b0;
        send_vec(8, 1'b1, 0, 2'd0, 8'd32, 8'sd0, 1'b0);
        bad = 1'b0;
        @(negedge i_clk);
        for (int i = 0; i < 4; i++) begin
            if (o_busy !== 1'b1 || o_var_done !== 1'b0) bad = 1'b1;
            i_valid = 1'b1; i_x = 9'sd100;
            @(negedge i_clk);
        end
        if (o_busy !== 1'b1 || o_var_done !== 1'b0) bad = 1'b1;
        checks++; if (bad) begin errors++; $display("FAIL late_wait_hold got=left_wait exp=held"); end
        i_valid = 1'b0; i_x = 9'sd0; i_Ex_done = 1'b1; i_Ex = 8'sd4;
        @(negedge i_clk);
        i_Ex_done = 1'b0;
        wait_done(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL late_latency got=%0d exp=3", n); end
        checks++; if (o_var !== 16'd9) begin errors++; $display("FAIL late_var got=%0d exp=9", o_var); end
        @(negedge i_clk);
    endtask

    task automatic test_mid_reset();
        bit seen;
        i_valid = 1'b1; i_x = 9'sd5; i_alpha = 2'd0; i_inv_n = 8'd32;
        repeat (2) @(negedge i_clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", o_busy); end
        i_rstn = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
        checks++; if (o_var !== 16'd0) begin errors++; $display("FAIL midrst_var got=%0d exp=0", o_var); end
        checks++; if (o_ovf !== 1'b0 || o_var_done !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%b%b exp=00", o_ovf, o_var_done); end
        @(negedge i_clk);
        i_valid = 1'b0; i_rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            if (o_var_done !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_done got=1 exp=0"); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b exp=0", o_busy); end
    endtask

    // eight ones: ex2 = 1, Ex^2 = 9 -> clamp to 0
    task automatic test_clamp();
        int n;
        send_vec(8, 1'b0, 1, 2'd0, 8'd32, 8'sd3, 1'b1);
        wait_done(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL clamp_latency got=%0d exp=5", n); end
        checks++; if (o_var !== 16'd0) begin errors++; $display("FAIL clamp_var got=%0d exp=0", o_var); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL clamp_ovf got=%b exp=0", o_ovf); end
        @(negedge i_clk);
    endtask

    // 256 * 65536 = 2^24: saturates to 16777215 (var 65535) or wraps to 0
    task automatic test_acc_limit();
        int n;
        logic [15:0] exp_var;
        logic        exp_ovf;
`ifdef VAR_UNIT_SAT_EN
        exp_var = 16'd65535; exp_ovf = 1'b1;
`else
        exp_var = 16'd0;     exp_ovf = 1'b0;
`endif
        send_vec(256, 1'b0, -256, 2'd0, 8'd1, 8'sd0, 1'b1);
        wait_done(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL acc_latency got=%0d exp=5", n); end
        checks++; if (o_var !== exp_var) begin errors++; $display("FAIL acc_var got=%0d exp=%0d", o_var, exp_var); end
        checks++; if (o_ovf !== exp_ovf) begin errors++; $display("FAIL acc_ovf got=%b exp=%b", o_ovf, exp_ovf); end
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_out_sat();
        test_ramp();
        test_alpha2();
        test_ex_late();
        test_mid_reset();
        test_clamp();
        test_acc_limit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/var_unit.md
VAR_UNIT -- requirements
Module: var_unit

Interface
REQ-001 SHALL have parameters: ACC_W, default 24, sum-of-squares accumulator width; OUT_W, default 16, variance output width.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port i_valid, input, 1: high while a sample is presented; one sample per cycle; a 1->0 transition ends the vector.
REQ-005 SHALL have port i_x, input, signed 9: input sample, the same stream fed to the mean stage.
REQ-006 SHALL have port i_alpha, input, 2: compression shift; sampled on the first valid cycle of a vector.
REQ-007 SHALL have port i_inv_n, input, 8: 1/N in unsigned Q0.8; sampled on the first valid cycle of a vector.
REQ-008 SHALL have port i_Ex, input, signed 8: mean from the upstream mean stage, uncompressed units.
REQ-009 SHALL have port i_Ex_done, input, 1: one-cycle strobe that qualifies i_Ex.
REQ-010 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port o_var_done, output, 1: one-cycle strobe that qualifies o_var.
REQ-012 SHALL have port o_var, output, unsigned OUT_W: variance in uncompressed units; held until the next done.
REQ-013 SHALL have port o_ovf, output, 1: sticky flag, set on accumulator or output saturation; cleared at the start of the next vector.

Function
REQ-014 SHALL implement FSM IDLE -> ACC -> WAIT -> CALC1 -> CALC2 -> DONE -> IDLE.
REQ-015 IDLE->ACC: on i_valid=1; that cycle's sample is accumulated; acc, ex_flag and o_ovf are cleared.
REQ-016 ACC, per valid cycle: xc = i_x >>> alpha (arithmetic shift); acc += xc*xc (17-bit unsigned square).
REQ-017 ACC->WAIT: on the first edge with i_valid=0.
REQ-018 i_Ex_done in ACC or WAIT (including the same cycle as the end of the vector) SHALL latch i_Ex and set ex_flag.
REQ-019 WAIT->CALC1: on the edge where ex_flag=1, or i_Ex_done=1.
REQ-020 CALC1: ex2 = ((acc*inv_n) >> 8) << (2*alpha), 30-bit unsigned; ex_sq = Ex*Ex.
REQ-021 CALC2: diff = ex2 - ex_sq; a negative diff clamps to 0; diff > 2^OUT_W-1 saturates and sets o_ovf.
REQ-022 DONE: o_var_done=1 for exactly one cycle with o_var updated, then IDLE.
REQ-023 Latency: o_var_done rises 3 edges after the WAIT->CALC1 edge.
REQ-024 i_valid=1 in WAIT/CALC1/CALC2/DONE: samples ignored; no new vector until IDLE.
REQ-025 i_Ex_done outside ACC/WAIT: ignored.
REQ-026 All arithmetic SHALL floor; no rounding.

Reset
REQ-027 While i_rstn=0: state=IDLE; acc, ex_flag, latched Ex/alpha/inv_n=0; o_busy=0, o_var_done=0, o_var=0, o_ovf=0.
REQ-028 Reset asserted mid-vector SHALL abandon the vector; no o_var_done is produced for it.

Configuration
REQ-029 Macro VAR_UNIT_SAT_EN.
- Defined: acc saturates at 2^ACC_W-1 and sets o_ovf.
- Undefined: acc wraps modulo 2^ACC_W; o_ovf reflects output saturation only.

Structure
REQ-030 Shared package layernorm_pkg SHALL hold: X_W=9, EX_W=8, ALPHA_W=2, INV_N_W=8, and the FSM state enum.
REQ-031 The compress-and-square datapath SHALL be sub-module comp_square (i_x, i_alpha -> 17-bit square), combinational.

Verification
REQ-032 x=1..8, alpha=0, inv_n=32, i_Ex=4 strobed with the last sample -> o_var=9 (25-16), done 3 edges after WAIT.
REQ-033 Same x, alpha=2 -> squares sum 8, ex2=16, o_var=0.
REQ-034 Eight x=1, alpha=0, inv_n=32, i_Ex=3 -> diff 1-9 negative -> o_var=0, o_ovf=0.
REQ-035 256 samples x=-256, alpha=0: VAR_UNIT_SAT_EN defined -> acc=16777215, o_ovf=1; undefined -> acc=0.
REQ-036 i_Ex_done arrives 5 cycles after i_valid falls -> FSM holds in WAIT, done follows 3 edges later; i_rstn pulsed in ACC -> all outputs 0, no done.
